// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: address width, instruction width, reset PC, fetch FSM states.
// Latency: none (declarations only).
// Backpressure: n/a.
package instruction_fetch_pkg;

  // Default instruction-address width (word addressed, 256 words).
  localparam int IF_PC_W     = 8;
  // Instruction word width.
  localparam int IF_INSTR_W  = 32;
  // First address fetched after reset.
  localparam int IF_RESET_PC = 0;

  // Fetch FSM: RUN issues addresses, HALTED only drains the held word.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } if_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: drives a synchronous imem, presents one word per cycle to decode.
// Latency: word for address A is presented the cycle after the edge that sampled A.
// Backpressure: out_ready low holds out_pc/out_instr by re-reading the held address.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_W     = IF_PC_W,
  parameter int RESET_PC = IF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [IF_INSTR_W-1:0] imem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IF_INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]       out_pc,
  input  logic                  redirect_valid,
  input  logic [PC_W-1:0]       redirect_target,
  input  logic                  halt_req,
  output logic [15:0]           fetched_count
);

  localparam logic [0:0]      ST_RUN     = RUN;
  localparam logic [0:0]      ST_HALTED  = HALTED;
  localparam logic [PC_W-1:0] RESET_ADDR = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic            r_resp_valid;
  logic [0:0]      r_state;
  logic [15:0]     r_fetched_count;

  logic w_run;
  logic w_halt;
  logic w_redirect;
  logic w_adv;
  logic w_accept;

  // Halt outranks redirect, and a halted fetch ignores redirects entirely.
  assign w_run      = (r_state == ST_RUN);
  assign w_halt     = w_run && halt_req;
  assign w_redirect = w_run && redirect_valid && !halt_req;
  assign w_adv      = !r_resp_valid || out_ready;

  // A word presented alongside a taken redirect is wrong-path and is never accepted.
  assign out_valid     = r_resp_valid && !w_redirect && !reset;
  assign w_accept      = out_valid && out_ready;
  assign out_instr     = imem_data;
  assign out_pc        = r_resp_pc;
  assign fetched_count = r_fetched_count;

  // Next memory address: reset, redirect, advance, else re-read the held word.
  always_comb begin
    imem_addr = r_resp_pc;
    if (reset) begin
      imem_addr = RESET_ADDR;
    end else if (w_redirect) begin
      imem_addr = redirect_target;
    end else if (w_run && !halt_req && w_adv) begin
      imem_addr = r_fetch_pc;
    end
  end

  // Fetch PC, response register and RUN/HALTED state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc   <= RESET_ADDR;
      r_resp_pc    <= '0;
      r_resp_valid <= 1'b0;
      r_state      <= ST_RUN;
    end else if (w_halt) begin
      // No new address issued; a pending word stays until decode takes it.
      r_state <= ST_HALTED;
      if (w_accept) begin
        r_resp_valid <= 1'b0;
      end
    end else if (w_redirect) begin
      r_resp_pc    <= redirect_target;
      r_resp_valid <= 1'b1;
      r_fetch_pc   <= redirect_target + PC_ONE;
    end else if (w_run && w_adv) begin
      r_resp_pc    <= r_fetch_pc;
      r_resp_valid <= 1'b1;
      r_fetch_pc   <= r_fetch_pc + PC_ONE;
    end else if (!w_run && w_accept) begin
      r_resp_valid <= 1'b0;
    end
  end

  // Accepted-word counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetched_count <= '0;
    end else if (w_accept && (r_fetched_count != 16'hFFFF)) begin
      r_fetched_count <= r_fetched_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed stimulus with a scoreboard of expected accepted PCs.
// Latency: memory model returns the word for the address sampled at the previous edge.
// Backpressure: out_ready is driven directly by the stimulus.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        halt_req;
  logic [15:0] fetched_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  instruction_fetch #(.PC_W(8), .RESET_PC(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .fetched_count   (fetched_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory whose word at each address equals the address.
  always @(posedge clk) imem_data <= {24'd0, imem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got pc %0d expected no accept", out_pc);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", 32'(out_pc), 32'(e));
        chk("sb_instr", out_instr, 32'(e));
      end
    end
  end

  initial begin
    reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    redirect_target = 8'd0; halt_req = 1'b0;

    // Two reset cycles, then release.
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_count", 32'(fetched_count), 0);
    for (int a = 0; a <= 9; a++) exp_q.push_back(8'(a));
    step();
    @(negedge clk);
    chk("first_valid", 32'(out_valid), 1);
    step(); step();

    // Stall three cycles on out_pc=2.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_pc", 32'(out_pc), 2);
      chk("stall_instr", out_instr, 2);
      chk("stall_addr", 32'(imem_addr), 2);
      step();
    end
    out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("count_after4", 32'(fetched_count), 4);
    for (int i = 0; i < 6; i++) step();

    // Redirect to 7 while out_pc=10.
    redirect_valid = 1'b1; redirect_target = 8'd7;
    @(negedge clk);
    chk("redir_valid", 32'(out_valid), 0);
    chk("redir_addr", 32'(imem_addr), 7);
    chk("redir_count", 32'(fetched_count), 10);
    exp_q.push_back(8'd7); exp_q.push_back(8'd8); exp_q.push_back(8'd9);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_not_counted", 32'(fetched_count), 10);
    step(); step(); step();

    // Redirect to 254 to exercise wrap.
    redirect_valid = 1'b1; redirect_target = 8'd254;
    @(negedge clk);
    chk("wrap_redir_valid", 32'(out_valid), 0);
    exp_q.push_back(8'd254); exp_q.push_back(8'd255);
    exp_q.push_back(8'd0);   exp_q.push_back(8'd1);
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Stall at out_pc=5, then halt together with a redirect.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'd5;
    step();
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 8'd33;
    @(negedge clk);
    chk("halt_pc", 32'(out_pc), 5);
    chk("halt_valid", 32'(out_valid), 1);
    chk("halt_addr", 32'(imem_addr), 5);
    chk("halt_count", 32'(fetched_count), 17);
    step();
    halt_req = 1'b0;
    @(negedge clk);
    chk("halted_valid", 32'(out_valid), 1);
    chk("halted_addr", 32'(imem_addr), 5);
    exp_q.push_back(8'd5);
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_target = 8'd33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halted_drained_valid", 32'(out_valid), 0);
      chk("halted_frozen_count", 32'(fetched_count), 18);
      chk("halted_addr_hold", 32'(imem_addr), 5);
      step();
    end

    // Reset exits HALTED; fetch 0,1 then stall at 20.
    redirect_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    @(negedge clk);
    chk("rst2_count", 32'(fetched_count), 0);
    step(); step(); step();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'd20;
    step();
    redirect_valid = 1'b0;
    step();
    @(negedge clk);
    chk("stall20_pc", 32'(out_pc), 20);
    chk("stall20_count", 32'(fetched_count), 2);

    // Reset mid-stall and mid-redirect.
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 8'd40;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_addr", 32'(imem_addr), 0);
    step();
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_count", 32'(fetched_count), 0);
    chk("post_rst_addr", 32'(imem_addr), 0);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    step(); step(); step(); step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("final_count", 32'(fetched_count), 3);
    chk("final_pc", 32'(out_pc), 3);
    step();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 8, instruction-address width (word addressed, 256 words).
REQ-002 SHALL have parameter RESET_PC, default 0, first address fetched after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  PC_W  word address to the synchronous instruction memory; sampled by memory at each rising edge.
REQ-006 imem_data  input  32  memory word for the address sampled at the previous edge.
REQ-007 out_valid  output  1  out_instr/out_pc hold a fetched word.
REQ-008 out_ready  input  1  decode accepts the word this cycle.
REQ-009 out_instr  output  32  fetched instruction (imem_data passed through).
REQ-010 out_pc  output  PC_W  address of out_instr.
REQ-011 redirect_valid  input  1  taken branch/jump from execute.
REQ-012 redirect_target  input  PC_W  new fetch address.
REQ-013 halt_req  input  1  stop fetching (single-cycle pulse or level).
REQ-014 fetched_count  output  16  number of accepted words.

Function
REQ-015 State: fetch_pc (next address to issue), resp_pc, resp_valid, state in {RUN, HALTED}, fetched_count.
REQ-016 Accept = out_valid && out_ready; adv = !resp_valid || out_ready.
REQ-017 imem_addr (combinational), priority order: redirect_valid -> redirect_target; state RUN and adv -> fetch_pc; otherwise -> resp_pc (memory re-reads held word so imem_data stays stable).
REQ-018 out_valid = resp_valid && !redirect_valid; word presented during a redirect is discarded, never accepted.
REQ-019 RUN, redirect_valid: resp_pc <= redirect_target, resp_valid <= 1, fetch_pc <= redirect_target+1.
REQ-020 RUN, no redirect, adv: resp_pc <= fetch_pc, resp_valid <= 1, fetch_pc <= fetch_pc+1.
REQ-021 RUN, no redirect, !adv: resp_pc, resp_valid, fetch_pc hold.
REQ-022 Latency: word for address A is presented in the cycle after the edge that sampled A; sustained throughput one word per cycle when out_ready=1.
REQ-023 PC arithmetic modulo 2^PC_W: 255+1 wraps to 0, no flag.
REQ-024 halt_req high at an edge in RUN: state <= HALTED; no new address issued at that edge; pending word (if resp_valid) stays presented until accepted, then resp_valid <= 0.
REQ-025 halt_req and redirect_valid in the same cycle: halt wins, redirect ignored, pending word still delivered.
REQ-026 HALTED: redirect_valid ignored (out_valid = resp_valid), imem_addr = resp_pc; exit only via reset.
REQ-027 fetched_count increments by 1 on each accept, saturates at 0xFFFF.

Reset
REQ-028 reset high at an edge: fetch_pc <= RESET_PC, resp_valid <= 0, resp_pc <= 0, fetched_count <= 0, state <= RUN; overrides all other inputs including mid-stall and mid-redirect.
REQ-029 During reset cycles out_valid=0 and imem_addr=RESET_PC; first fetch issues at the first edge with reset low.

Structure
REQ-030 Shared package instruction_fetch_pkg SHALL hold PC_W, instruction width 32, RESET_PC and the state enum {RUN, HALTED}; the decode stage imports the same package.
REQ-031 Single module; no sub-module is natural (response register and next-PC mux are too small to split).

Verification
REQ-032 Reset 2 cycles, out_ready=1, memory words = address value -> out_pc 0,1,2,3 on consecutive cycles, first out_valid one cycle after reset release, fetched_count=4 after 4 accepts.
REQ-033 Stall: out_ready=0 for 3 cycles while out_pc=2 -> out_pc=2, out_instr unchanged, imem_addr=2 throughout; after release next out_pc=3, no word skipped or duplicated.
REQ-034 Redirect to 7 while out_pc=10 and out_ready=1 -> out_valid=0 that cycle, 10 not counted, next out_pc 7,8,9.
REQ-035 Redirect to 254 -> out_pc 254,255,0,1.
REQ-036 halt_req with redirect_valid same cycle while out_pc=5 stalled -> 5 delivered when out_ready rises, then out_valid stays 0 and fetched_count frozen.
REQ-037 Reset asserted during stall at out_pc=20 -> next cycle out_valid=0, fetched_count=0; after release fetch restarts at address 0.
